// File: rtl/fir_decim_buffer.sv
// Post-FIR stage: drops the filter fill transient, decimates by DECIM and buffers kept
// samples in a first-word-fall-through FIFO drained by a valid/ready handshake.
module fir_decim_buffer #(
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned DECIM   = 2,
  parameter int unsigned DISCARD = 20,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ADDR_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]          fifo_count,
  output logic                     overflow
);

  localparam int unsigned WarmW = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;
  localparam int unsigned PhW   = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [WarmW-1:0] WarmLast  = WarmW'((DISCARD > 0) ? DISCARD - 1 : 0);
  localparam logic [PhW-1:0]   PhLast    = PhW'(DECIM - 1);
  localparam logic [ADDR_W:0]  CountFull = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {StWarmup, StRun} state_e;

  // With nothing to discard the block comes out of reset already running.
  localparam state_e StReset = (DISCARD == 0) ? StRun : StWarmup;

  state_e                 state_q, state_d;
  logic [WarmW-1:0]       warm_cnt_q, warm_cnt_d;
  logic [PhW-1:0]         phase_q, phase_d;
  logic [ADDR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]        count_q, count_d;
  logic                   overflow_q;
  logic [DATA_W-1:0]      mem_q [DEPTH];

  logic keep, push, pop;

  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    phase_d    = phase_q;
    keep       = 1'b0;
    unique case (state_q)
      StWarmup: begin
        if (in_valid) begin
          warm_cnt_d = warm_cnt_q + 1'b1;
          if (warm_cnt_q == WarmLast) begin
            state_d = StRun;
            phase_d = '0;
          end
        end
      end
      StRun: begin
        if (in_valid) begin
          keep    = (phase_q == '0);
          phase_d = (phase_q == PhLast) ? '0 : phase_q + 1'b1;
        end
      end
      default: state_d = StReset;
    endcase
  end

  assign out_valid  = (count_q != '0);
  assign out_data   = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

  // A full FIFO still accepts a sample when a word leaves on the same edge.
  assign pop  = out_valid && out_ready;
  assign push = keep && ((count_q != CountFull) || pop);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StReset;
      warm_cnt_q <= '0;
      phase_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      phase_q    <= phase_d;
      count_q    <= count_d;
      overflow_q <= overflow_q | (keep & ~push);
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage is cleared so out_data reads 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Scoreboard bench for fir_decim_buffer: a reference model predicts FIFO contents,
// count and overflow; every cycle the DUT outputs are compared against it.
module tb_fir_decim_buffer;

  localparam int unsigned DataW   = 12;
  localparam int unsigned Decim   = 2;
  localparam int unsigned Discard = 20;
  localparam int unsigned Depth   = 8;
  localparam int unsigned AddrW   = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic signed [DataW-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [DataW-1:0] out_data;
  logic [AddrW:0]          fifo_count;
  logic                    overflow;

  fir_decim_buffer #(
    .DATA_W  (DataW),
    .DECIM   (Decim),
    .DISCARD (Discard),
    .DEPTH   (Depth),
    .ADDR_W  (AddrW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int dut_pops = 0;
  int mark;

  // Reference model state
  int q[$];
  int m_warm;
  bit m_run;
  int m_phase;
  bit m_ovf;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_warm  = 0;
    m_run   = (Discard == 0);
    m_phase = 0;
    m_ovf   = 0;
  endtask

  // Called just after a falling edge: drive inputs, compare registered outputs against
  // the model, advance the model across the next rising edge.
  task automatic cycle(input logic v, input int d, input logic r);
    bit pop, kept, push;
    in_valid  = v;
    in_data   = DataW'(d);
    out_ready = r;
    check("out_valid", out_valid, (q.size() != 0));
    if (q.size() != 0) check("out_data", out_data, q[0]);
    check("fifo_count", fifo_count, q.size());
    check("overflow", overflow, m_ovf);
    if (out_valid && r) dut_pops++;
    pop  = (q.size() != 0) && r;
    kept = v && m_run && (m_phase == 0);
    push = kept && ((q.size() < Depth) || pop);
    if (pop) void'(q.pop_front());
    if (push) q.push_back(d);
    if (kept && !push) m_ovf = 1'b1;
    if (v) begin
      if (!m_run) begin
        m_warm++;
        if (m_warm == Discard) begin
          m_run   = 1'b1;
          m_phase = 0;
        end
      end else begin
        m_phase = (m_phase + 1) % Decim;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, r);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b0;

    // Ramp: expect 20,22,...,38
    mark = dut_pops;
    for (int i = 0; i < 40; i++) cycle(1'b1, i, 1'b1);
    idle(3, 1'b1);
    check("ramp_words", dut_pops - mark, 10);

    // Signed extremes, each followed by a decimated-away filler
    begin
      int neg[4] = '{-512, -1, 2047, -2048};
      for (int i = 0; i < 4; i++) begin
        cycle(1'b1, neg[i], 1'b1);
        cycle(1'b1, 77, 1'b1);
      end
    end
    idle(3, 1'b1);

    // Push and pop together at count 1
    cycle(1'b1, 300, 1'b0);
    cycle(1'b1, 0, 1'b0);
    cycle(1'b1, 301, 1'b1);
    check("cnt1_pushpop", fifo_count, 1);
    cycle(1'b1, 0, 1'b1);
    idle(2, 1'b1);

    // Fill to full, then push and pop on the same edge
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 500 + i, 1'b0);
      cycle(1'b1, 0, 1'b0);
    end
    check("full_count", fifo_count, 8);
    cycle(1'b1, 600, 1'b1);
    check("full_pushpop_count", fifo_count, 8);
    check("full_pushpop_ovf", overflow, 0);
    cycle(1'b1, 0, 1'b0);
    idle(10, 1'b1);

    // Gapped input: phase holds across gaps
    mark = dut_pops;
    for (int i = 0; i < 24; i++) cycle((i % 2) == 0, 400 + i, 1'b1);
    idle(2, 1'b1);
    check("gapped_words", dut_pops - mark, 6);

    // Overflow: 10 kept samples into an 8-entry FIFO
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 100 + i, 1'b0);
      cycle(1'b1, 0, 1'b0);
    end
    check("ovf_count", fifo_count, 8);
    check("ovf_set", overflow, 1);
    mark = dut_pops;
    idle(10, 1'b1);
    check("ovf_drain_words", dut_pops - mark, 8);

    // Refill to 5 then reset mid-run
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 700 + i, 1'b0);
      cycle(1'b1, 0, 1'b0);
    end
    check("pre_rst_count", fifo_count, 5);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_fifo_count", fifo_count, 0);
    check("mid_rst_overflow", overflow, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    mark = dut_pops;
    for (int i = 0; i < 40; i++) cycle(1'b1, 1000 + i, 1'b1);
    idle(3, 1'b1);
    check("post_rst_words", dut_pops - mark, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
